// File: rtl/pan_stream_luhn.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// pan_stream_luhn : PAN digit ingest, skid re-stream, IIN capture, Luhn check
// Revision 1.0
// ============================================================================
module pan_stream_luhn #(
  parameter int  MIN_LEN    = 12,
  parameter int  MAX_LEN    = 19,
  parameter int  IIN_DIGITS = 8,
  localparam int LEN_W      = $clog2(MAX_LEN + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    pan_end_i,
  input  logic                    abort_i,
  input  logic                    digit_valid_i,
  output logic                    digit_ready_o,
  input  logic [3:0]              digit_i,
  output logic [3:0]              s_digit_o,
  output logic                    s_valid_o,
  output logic                    s_first_o,
  output logic                    s_last_o,
  output logic [4*IIN_DIGITS-1:0] iin_prefix_o,
  output logic                    iin_ready_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [LEN_W-1:0]        len_final_o,
  output logic                    length_ok_o,
  output logic                    luhn_ok_o,
  output logic [2:0]              error_code_o,
  output logic                    pan_ok_o
);

  localparam logic [LEN_W-1:0]        C_LEN_MIN      = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]        C_LEN_MAX      = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]        C_LEN_SAT      = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]        C_IIN_LAST     = LEN_W'(IIN_DIGITS - 1);
  localparam logic [4*IIN_DIGITS-1:0] C_PREFIX_EMPTY = {IIN_DIGITS{4'hF}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [3:0] add10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  function automatic logic [3:0] dbl10(input logic [3:0] d);
    logic [4:0] t;
    t = {d, 1'b0};
    if (t > 5'd9) t = t - 5'd9;
    return t[3:0];
  endfunction

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [3:0]              sum_e_q, sum_e_d;
  logic [3:0]              sum_o_q, sum_o_d;
  logic [2:0]              err_q, err_d;
  logic                    pend_q, pend_d;
  logic [3:0]              hold_q, hold_d;
  logic                    hold_vld_q, hold_vld_d;
  logic                    hold_first_q, hold_first_d;
  logic [3:0]              s_digit_q, s_digit_d;
  logic                    s_valid_q, s_valid_d;
  logic                    s_first_q, s_first_d;
  logic                    s_last_q, s_last_d;
  logic [4*IIN_DIGITS-1:0] prefix_q, prefix_d;
  logic                    iin_rdy_q, iin_rdy_d;
  logic                    res_valid_q, res_valid_d;

  logic       w_accept;
  logic       w_keep;
  logic       w_is_bcd;
  logic       w_restart;
  logic [3:0] w_dbl;
  logic [3:0] w_luhn_sel;
  logic       w_len_ok;

  assign w_accept  = (state_q == S_COLLECT) && digit_valid_i;
  // Digits past MAX_LEN are counted but never enter the stream, Luhn or IIN.
  assign w_keep    = w_accept && (len_q < C_LEN_MAX);
  assign w_is_bcd  = (digit_i <= 4'd9);
  assign w_restart = start_i && ((state_q == S_IDLE) || (state_q == S_COLLECT));
  assign w_dbl     = dbl10(digit_i);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_e_d      = sum_e_q;
    sum_o_d      = sum_o_q;
    err_d        = err_q;
    pend_d       = pend_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    hold_first_d = hold_first_q;
    s_digit_d    = s_digit_q;
    s_valid_d    = 1'b0;
    s_first_d    = 1'b0;
    s_last_d     = 1'b0;
    prefix_d     = prefix_q;
    iin_rdy_d    = iin_rdy_q;
    res_valid_d  = res_valid_q;

    if (w_restart) begin
      state_d    = S_COLLECT;
      len_d      = '0;
      sum_e_d    = 4'd0;
      sum_o_d    = 4'd0;
      err_d      = {pend_q, 2'b00};
      pend_d     = 1'b0;
      hold_vld_d = 1'b0;
      prefix_d   = C_PREFIX_EMPTY;
      iin_rdy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (digit_valid_i || pan_end_i) err_d[2] = 1'b1;
        end
        S_COLLECT: begin
          if (w_keep) begin
            if (hold_vld_q) begin
              s_valid_d = 1'b1;
              s_digit_d = hold_q;
              s_first_d = hold_first_q;
            end
            hold_d       = digit_i;
            hold_vld_d   = 1'b1;
            hold_first_d = (len_q == '0);
            if (len_q == C_IIN_LAST) iin_rdy_d = 1'b1;
            for (int i = 0; i < IIN_DIGITS; i++) begin
              if (len_q == LEN_W'(i)) prefix_d[4*(IIN_DIGITS-1-i) +: 4] = digit_i;
            end
            if (!w_is_bcd) begin
              err_d[0] = 1'b1;
            end else if (len_q[0]) begin
              sum_e_d = add10(sum_e_q, digit_i);
              sum_o_d = add10(sum_o_q, w_dbl);
            end else begin
              sum_e_d = add10(sum_e_q, w_dbl);
              sum_o_d = add10(sum_o_q, digit_i);
            end
          end
          if (w_accept) begin
            len_d = w_keep ? (len_q + LEN_W'(1)) : C_LEN_SAT;
            if (!w_keep) err_d[1] = 1'b1;
          end
          if (pan_end_i) begin
            if (w_keep) begin
              state_d = S_FLUSH;
            end else begin
              s_valid_d   = hold_vld_q;
              s_digit_d   = hold_vld_q ? hold_q : s_digit_q;
              s_first_d   = hold_vld_q && hold_first_q;
              s_last_d    = hold_vld_q;
              hold_vld_d  = 1'b0;
              res_valid_d = 1'b1;
              state_d     = S_DONE;
            end
          end
        end
        S_FLUSH: begin
          s_valid_d   = 1'b1;
          s_digit_d   = hold_q;
          s_first_d   = hold_first_q;
          s_last_d    = 1'b1;
          hold_vld_d  = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          // Misuse while a record is pending is charged to the following PAN.
          if (digit_valid_i || pan_end_i) pend_d = 1'b1;
          if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (abort_i) begin
      state_d     = S_IDLE;
      len_d       = '0;
      sum_e_d     = 4'd0;
      sum_o_d     = 4'd0;
      err_d       = 3'b000;
      pend_d      = 1'b0;
      hold_vld_d  = 1'b0;
      s_valid_d   = 1'b0;
      s_first_d   = 1'b0;
      s_last_d    = 1'b0;
      prefix_d    = C_PREFIX_EMPTY;
      iin_rdy_d   = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      sum_e_q      <= 4'd0;
      sum_o_q      <= 4'd0;
      err_q        <= 3'b000;
      pend_q       <= 1'b0;
      hold_q       <= 4'd0;
      hold_vld_q   <= 1'b0;
      hold_first_q <= 1'b0;
      s_digit_q    <= 4'd0;
      s_valid_q    <= 1'b0;
      s_first_q    <= 1'b0;
      s_last_q     <= 1'b0;
      prefix_q     <= C_PREFIX_EMPTY;
      iin_rdy_q    <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_e_q      <= sum_e_d;
      sum_o_q      <= sum_o_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      hold_first_q <= hold_first_d;
      s_digit_q    <= s_digit_d;
      s_valid_q    <= s_valid_d;
      s_first_q    <= s_first_d;
      s_last_q     <= s_last_d;
      prefix_q     <= prefix_d;
      iin_rdy_q    <= iin_rdy_d;
      res_valid_q  <= res_valid_d;
    end
  end

  // Even length: rightmost digit sits at an odd index, so even indices are doubled.
  assign w_luhn_sel = len_q[0] ? sum_o_q : sum_e_q;
  assign w_len_ok   = (len_q >= C_LEN_MIN) && (len_q <= C_LEN_MAX);

  assign digit_ready_o = (state_q == S_COLLECT);
  assign s_digit_o     = s_digit_q;
  assign s_valid_o     = s_valid_q;
  assign s_first_o     = s_first_q;
  assign s_last_o      = s_last_q;
  assign iin_prefix_o  = prefix_q;
  assign iin_ready_o   = iin_rdy_q;
  assign res_valid_o   = res_valid_q;
  assign len_final_o   = len_q;
  assign error_code_o  = err_q;
  assign length_ok_o   = res_valid_q && w_len_ok;
  assign luhn_ok_o     = res_valid_q && (len_q != '0) && (w_luhn_sel == 4'd0);
  assign pan_ok_o      = length_ok_o && luhn_ok_o && (err_q == 3'b000);

endmodule
`default_nettype wire

// File: tb/tb_pan_stream_luhn.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// tb_pan_stream_luhn : directed scoreboard bench for pan_stream_luhn
// Revision 1.0
// ============================================================================
module tb_pan_stream_luhn;

  localparam int MIN_LEN    = 12;
  localparam int MAX_LEN    = 19;
  localparam int IIN_DIGITS = 8;
  localparam int LEN_W      = $clog2(MAX_LEN + 2);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_i, pan_end_i, abort_i, digit_valid_i, res_ready_i;
  logic [3:0]              digit_i;
  logic                    digit_ready_o;
  logic [3:0]              s_digit_o;
  logic                    s_valid_o, s_first_o, s_last_o;
  logic [4*IIN_DIGITS-1:0] iin_prefix_o;
  logic                    iin_ready_o, res_valid_o;
  logic [LEN_W-1:0]        len_final_o;
  logic                    length_ok_o, luhn_ok_o, pan_ok_o;
  logic [2:0]              error_code_o;

  pan_stream_luhn #(
    .MIN_LEN   (MIN_LEN),
    .MAX_LEN   (MAX_LEN),
    .IIN_DIGITS(IIN_DIGITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pan_end_i    (pan_end_i),
    .abort_i      (abort_i),
    .digit_valid_i(digit_valid_i),
    .digit_ready_o(digit_ready_o),
    .digit_i      (digit_i),
    .s_digit_o    (s_digit_o),
    .s_valid_o    (s_valid_o),
    .s_first_o    (s_first_o),
    .s_last_o     (s_last_o),
    .iin_prefix_o (iin_prefix_o),
    .iin_ready_o  (iin_ready_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .len_final_o  (len_final_o),
    .length_ok_o  (length_ok_o),
    .luhn_ok_o    (luhn_ok_o),
    .error_code_o (error_code_o),
    .pan_ok_o     (pan_ok_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       f;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [LEN_W-1:0]        len;
    logic [2:0]              err;
    logic                    lok;
    logic                    uok;
    logic                    pok;
    logic [4*IIN_DIGITS-1:0] pre;
  } res_t;

  beat_t      beat_q[$];
  res_t       res_q[$];
  beat_t      mon_e;
  int         checks    = 0;
  int         errors    = 0;
  int         beats     = 0;
  int         exp_beats = 0;
  logic [3:0] pan[0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bench-side reference: Luhn computed from the right-hand end of the PAN.
  task automatic model_pan(input int n, input bit complete);
    int    ns, emit, len, sum, d2;
    bit    nb;
    beat_t b;
    res_t  r;
    ns   = (n > MAX_LEN) ? MAX_LEN : n;
    emit = complete ? ns : ns - 1;
    for (int k = 0; k < emit; k++) begin
      b.d = pan[k];
      b.f = (k == 0);
      b.l = complete && (k == ns - 1);
      beat_q.push_back(b);
    end
    exp_beats = emit;
    if (complete) begin
      len = (n > MAX_LEN) ? MAX_LEN + 1 : n;
      sum = 0;
      nb  = 1'b0;
      r.pre = {IIN_DIGITS{4'hF}};
      for (int k = 0; k < ns; k++) begin
        if (k < IIN_DIGITS) r.pre[4*(IIN_DIGITS-1-k) +: 4] = pan[k];
        if (pan[k] > 4'd9) begin
          nb = 1'b1;
        end else begin
          d2 = int'(pan[k]);
          if (((len - 1 - k) % 2) == 1) begin
            d2 = 2 * d2;
            if (d2 > 9) d2 = d2 - 9;
          end
          sum = sum + d2;
        end
      end
      r.len = LEN_W'(len);
      r.err = {1'b0, 1'(n > MAX_LEN), nb};
      r.lok = (len >= MIN_LEN) && (len <= MAX_LEN);
      r.uok = (len != 0) && ((sum % 10) == 0);
      r.pok = r.lok && r.uok && (r.err == 3'b000);
      res_q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && s_valid_o) begin
      beats++;
      chk("beat_expected", 64'(beat_q.size() != 0), 64'd1);
      if (beat_q.size() != 0) begin
        mon_e = beat_q.pop_front();
        chk("beat", {s_digit_o, s_first_o, s_last_o}, 64'(mon_e));
      end
    end
  end

  task automatic run_pan(input int n, input bit coinc);
    model_pan(n, 1'b1);
    beats   = 0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("digit_ready_collect", 64'(digit_ready_o), 64'd1);
    for (int i = 0; i < n; i++) begin
      digit_valid_i = 1'b1;
      digit_i       = pan[i];
      pan_end_i     = coinc && (i == n - 1);
      @(posedge clk); #1;
    end
    digit_valid_i = 1'b0;
    if (!coinc) begin
      pan_end_i = 1'b1;
      @(posedge clk); #1;
      pan_end_i = 1'b0;
      chk("res_valid_plus1", 64'(res_valid_o), 64'd1);
    end else begin
      pan_end_i = 1'b0;
      chk("res_valid_plus1_low", 64'(res_valid_o), 64'd0);
      @(posedge clk); #1;
      chk("res_valid_plus2", 64'(res_valid_o), 64'd1);
    end
  endtask

  task automatic take_result(input int bp);
    res_t e;
    chk("res_expected", 64'(res_q.size() != 0), 64'd1);
    if (res_q.size() != 0) begin
      e = res_q.pop_front();
      for (int c = 0; c < bp; c++) begin
        chk("bp_res_valid", 64'(res_valid_o), 64'd1);
        chk("bp_digit_ready", 64'(digit_ready_o), 64'd0);
        chk("bp_len_stable", 64'(len_final_o), 64'(e.len));
        start_i = 1'b1;
        @(posedge clk); #1;
      end
      start_i = 1'b0;
      chk("len_final", 64'(len_final_o), 64'(e.len));
      chk("error_code", 64'(error_code_o), 64'(e.err));
      chk("length_ok", 64'(length_ok_o), 64'(e.lok));
      chk("luhn_ok", 64'(luhn_ok_o), 64'(e.uok));
      chk("pan_ok", 64'(pan_ok_o), 64'(e.pok));
      chk("iin_prefix", 64'(iin_prefix_o), 64'(e.pre));
      res_ready_i = 1'b1;
      @(posedge clk); #1;
      res_ready_i = 1'b0;
      chk("res_valid_dropped", 64'(res_valid_o), 64'd0);
      chk("idle_digit_ready", 64'(digit_ready_o), 64'd0);
    end
    chk("beat_count", 64'(beats), 64'(exp_beats));
    chk("beat_q_drained", 64'(beat_q.size()), 64'd0);
  endtask

  task automatic load_visa(input logic [3:0] last);
    pan[0] = 4'd4;
    for (int k = 1; k < 32; k++) pan[k] = 4'd1;
    pan[15] = last;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_i = 1'b0; pan_end_i = 1'b0; abort_i = 1'b0;
    digit_valid_i = 1'b0; res_ready_i = 1'b0; digit_i = 4'd0;
    #12;
    chk("rst_s_valid", 64'(s_valid_o), 64'd0);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_len", 64'(len_final_o), 64'd0);
    chk("rst_err", 64'(error_code_o), 64'd0);
    chk("rst_s_digit", 64'(s_digit_o), 64'd0);
    chk("rst_prefix", 64'(iin_prefix_o), 64'hFFFF_FFFF);
    chk("rst_iin_ready", 64'(iin_ready_o), 64'd0);
    chk("rst_digit_ready", 64'(digit_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    digit_valid_i = 1'b1;
    @(posedge clk); #1;
    digit_valid_i = 1'b0;
    chk("proto_idle", 64'(error_code_o), 64'd4);

    load_visa(4'd1);
    run_pan(16, 1'b0);
    take_result(0);

    load_visa(4'd2);
    run_pan(16, 1'b1);
    take_result(5);

    for (int k = 0; k < 32; k++) pan[k] = 4'd0;
    run_pan(20, 1'b0);
    take_result(0);

    load_visa(4'd1);
    pan[5] = 4'hA;
    run_pan(16, 1'b0);
    take_result(0);

    load_visa(4'd1);
    model_pan(7, 1'b0);
    beats   = 0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      digit_valid_i = 1'b1;
      digit_i       = pan[i];
      @(posedge clk); #1;
    end
    digit_valid_i = 1'b0;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_res_valid", 64'(res_valid_o), 64'd0);
    chk("abort_s_valid", 64'(s_valid_o), 64'd0);
    chk("abort_iin_ready", 64'(iin_ready_o), 64'd0);
    chk("abort_digit_ready", 64'(digit_ready_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(res_valid_o), 64'd0);
    chk("abort_beats", 64'(beats), 64'(exp_beats));
    chk("abort_beat_q", 64'(beat_q.size()), 64'd0);

    model_pan(9, 1'b0);
    beats   = 0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      digit_valid_i = 1'b1;
      digit_i       = pan[i];
      @(posedge clk); #1;
      if (i == 6) chk("iin_ready_early", 64'(iin_ready_o), 64'd0);
      if (i == 7) begin
        chk("iin_ready_rise", 64'(iin_ready_o), 64'd1);
        chk("iin_prefix_live", 64'(iin_prefix_o), 64'h4111_1111);
      end
    end
    digit_valid_i = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_iin_ready", 64'(iin_ready_o), 64'd0);
    chk("mid_rst_prefix", 64'(iin_prefix_o), 64'hFFFF_FFFF);
    chk("mid_rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("mid_rst_len", 64'(len_final_o), 64'd0);
    chk("mid_rst_s_valid", 64'(s_valid_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("post_rst_digit_ready", 64'(digit_ready_o), 64'd0);
    chk("rst_beats", 64'(beats), 64'(exp_beats));
    chk("rst_beat_q", 64'(beat_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
